// File: rtl/y86_mem_access_pkg.sv
// Shared Y86-64 memory-stage definitions: icodes, status codes and the
// icode-to-memory-request decode used by the memory stage.
package y86_mem_access_pkg;

   localparam int DMEM_BYTES_DEF = 1024;

   typedef enum logic [3:0] {
      IHALT   = 4'h0,
      INOP    = 4'h1,
      IRRMOVQ = 4'h2,
      IIRMOVQ = 4'h3,
      IRMMOVQ = 4'h4,
      IMRMOVQ = 4'h5,
      IOPQ    = 4'h6,
      IJXX    = 4'h7,
      ICALL   = 4'h8,
      IRET    = 4'h9,
      IPUSHQ  = 4'hA,
      IPOPQ   = 4'hB
   } icode_e;

   typedef enum logic [3:0] {
      SAOK = 4'h1,
      SHLT = 4'h2,
      SADR = 4'h3,
      SINS = 4'h4
   } stat_e;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] data;
   } mem_req_t;

   // Address/data/direction selection for one instruction; non-memory
   // icodes produce an idle request with address 0.
   function automatic mem_req_t decode_mem(input logic [3:0]  icode,
                                           input logic [63:0] val_e,
                                           input logic [63:0] val_a,
                                           input logic [63:0] val_p);
      mem_req_t r;
      r = '0;
      case (icode)
         IRMMOVQ, IPUSHQ: begin
            r.wr   = 1'b1;
            r.addr = val_e;
            r.data = val_a;
         end
         ICALL: begin
            r.wr   = 1'b1;
            r.addr = val_e;
            r.data = val_p;
         end
         IMRMOVQ: begin
            r.rd   = 1'b1;
            r.addr = val_e;
         end
         IPOPQ, IRET: begin
            r.rd   = 1'b1;
            r.addr = val_a;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/y86_dmem.sv
// Byte-addressed data memory: 8-byte little-endian combinational read,
// synchronous write, clear-on-reset and quadword range check.
module y86_dmem
   import y86_mem_access_pkg::*;
#(
   parameter int DMEM_BYTES = DMEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        access,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic [63:0] rdata,
   output logic        addr_err
);

   localparam int          AW       = $clog2(DMEM_BYTES);
   localparam logic [63:0] MAX_ADDR = 64'(DMEM_BYTES - 8);

   logic [7:0]    mem [DMEM_BYTES];
   logic [AW-1:0] base;

   // Full 64-bit unsigned compare so addresses near 2^64 cannot wrap in range.
   assign addr_err = access && (addr > MAX_ADDR);
   assign base     = addr[AW-1:0];

   always_comb begin
      rdata = '0;
      if (rd_en && !addr_err) begin
         for (int i = 0; i < 8; i++)
            rdata[8*i +: 8] = mem[base + AW'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DMEM_BYTES; i++)
            mem[i] <= '0;
      end else if (wr_en && !addr_err) begin
         for (int i = 0; i < 8; i++)
            mem[base + AW'(i)] <= wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/y86_mem_access.sv
// Y86-64 sequential memory stage: request muxing, write qualification and
// architectural status generation around the data memory.
module y86_mem_access
   import y86_mem_access_pkg::*;
#(
   parameter int DMEM_BYTES = DMEM_BYTES_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  icode_i,
   input  logic [63:0] valE_i,
   input  logic [63:0] valA_i,
   input  logic [63:0] valP_i,
   input  logic        instr_valid_i,
   input  logic        imem_error_i,
   output logic [63:0] valM_o,
   output logic [3:0]  Stat_o
);

   mem_req_t req;
   logic     dmem_error;
   logic     rd_en;
   logic     wr_en;

   assign req = decode_mem(icode_i, valE_i, valA_i, valP_i);

   // Range errors are judged on the raw request so a bad store still reports ADR;
   // the commit is additionally blocked by fetch faults and reset.
   assign rd_en = req.rd && !rst_i;
   assign wr_en = req.wr && instr_valid_i && !imem_error_i && !rst_i;

   y86_dmem #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
      .clk      (clk_i),
      .rst      (rst_i),
      .access   (req.rd | req.wr),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .addr     (req.addr),
      .wdata    (req.data),
      .rdata    (valM_o),
      .addr_err (dmem_error)
   );

   always_comb begin
      Stat_o = SAOK;
      if (rst_i)
         Stat_o = SAOK;
      else if (imem_error_i || dmem_error)
         Stat_o = SADR;
      else if (!instr_valid_i)
         Stat_o = SINS;
      else if (icode_i == IHALT)
         Stat_o = SHLT;
   end

endmodule

// File: tb/tb_y86_mem_access.sv
// Directed and randomized check of the Y86-64 memory stage against a
// byte-array reference model.
module tb_y86_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  icode;
   logic [63:0] val_e, val_a, val_p;
   logic        valid, imem;
   logic [63:0] valm;
   logic [3:0]  stat;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  ref_mem [1024];
   logic [63:0] got_m;
   logic [3:0]  got_s;

   always #5 clk = ~clk;

   y86_mem_access dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .icode_i       (icode),
      .valE_i        (val_e),
      .valA_i        (val_a),
      .valP_i        (val_p),
      .instr_valid_i (valid),
      .imem_error_i  (imem),
      .valM_o        (valm),
      .Stat_o        (stat)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One instruction per clock: drive, check against the model before the edge,
   // then let the model absorb the edge.
   task automatic step(input logic r, input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p,
                       input logic v, input logic im);
      logic [63:0] addr, data, exp_m;
      logic        rd, wr, derr;
      logic [3:0]  exp_s;
      rst = r; icode = ic; val_e = e; val_a = a; val_p = p; valid = v; imem = im;
      rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
      addr = (ic == 4'h9 || ic == 4'hB) ? a : ((rd || wr) ? e : 64'd0);
      data = (ic == 4'h8) ? p : a;
      derr = (rd || wr) && (addr > 64'd1016);
      exp_m = '0;
      if (!r && rd && !derr)
         for (int k = 0; k < 8; k++) exp_m = exp_m | (64'(ref_mem[addr[9:0] + 10'(k)]) << (8 * k));
      if (r)                 exp_s = 4'd1;
      else if (im || derr)   exp_s = 4'd3;
      else if (!v)           exp_s = 4'd4;
      else if (ic == 4'h0)   exp_s = 4'd2;
      else                   exp_s = 4'd1;
      @(negedge clk);
      got_m = valm;
      got_s = stat;
      chk("valM", got_m, exp_m);
      chk("Stat", 64'(got_s), 64'(exp_s));
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h0;
      end else if (wr && !derr && v && !im) begin
         for (int k = 0; k < 8; k++) ref_mem[addr[9:0] + 10'(k)] = data[8*k +: 8];
      end
      #1;
   endtask

   initial begin
      logic [63:0] e, a;
      logic [3:0]  ic;
      int          sel;
      for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h0;

      step(1, 4'h1, 0, 0, 0, 1, 0);
      chk("reset valM", got_m, 64'h0);
      chk("reset Stat", 64'(got_s), 64'd1);

      step(0, 4'h4, 112, 64'h80, 0, 1, 0);
      chk("rmmovq Stat", 64'(got_s), 64'd1);
      step(0, 4'h5, 112, 0, 0, 1, 0);
      chk("mrmovq valM", got_m, 64'h80);
      chk("mrmovq Stat", 64'(got_s), 64'd1);

      step(0, 4'h8, 120, 0, 64'h40, 1, 0);
      step(0, 4'h9, 128, 120, 0, 1, 0);
      chk("ret valM", got_m, 64'h40);
      chk("ret Stat", 64'(got_s), 64'd1);

      step(0, 4'h0, 0, 0, 0, 1, 0);
      chk("halt Stat", 64'(got_s), 64'd2);
      chk("halt valM", got_m, 64'h0);

      step(0, 4'h9, 0, 1024, 0, 1, 0);
      chk("ret oob Stat", 64'(got_s), 64'd3);
      chk("ret oob valM", got_m, 64'h0);
      step(0, 4'hA, 1017, 64'hDEAD_BEEF, 0, 1, 0);
      chk("push oob Stat", 64'(got_s), 64'd3);
      step(0, 4'h5, 1016, 0, 0, 1, 0);
      chk("push oob mem", got_m, 64'h0);

      step(0, 4'h9, 0, 120, 0, 1, 1);
      chk("imem Stat", 64'(got_s), 64'd3);
      step(0, 4'hC, 0, 120, 0, 0, 0);
      chk("ins Stat", 64'(got_s), 64'd4);

      step(0, 4'h4, 200, 64'h5, 0, 0, 0);
      chk("invalid store Stat", 64'(got_s), 64'd4);
      step(0, 4'h5, 200, 0, 0, 1, 0);
      chk("invalid store mem", got_m, 64'h0);
      step(0, 4'hA, 208, 64'h7, 0, 1, 1);
      step(0, 4'h5, 208, 0, 0, 1, 0);
      chk("imem store mem", got_m, 64'h0);

      step(1, 4'h4, 112, 64'h99, 0, 1, 0);
      step(0, 4'h5, 112, 0, 0, 1, 0);
      chk("post-reset valM", got_m, 64'h0);

      step(0, 4'h4, 1016, 64'h1122_3344_5566_7788, 0, 1, 0);
      chk("top store Stat", 64'(got_s), 64'd1);
      step(0, 4'h5, 1016, 0, 0, 1, 0);
      chk("top load valM", got_m, 64'h1122_3344_5566_7788);
      step(0, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3, 0, 1, 0);
      chk("wrap store Stat", 64'(got_s), 64'd3);
      step(0, 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 0);
      chk("wrap load Stat", 64'(got_s), 64'd3);
      chk("wrap load valM", got_m, 64'h0);
      step(0, 4'h5, 1016, 0, 0, 1, 0);
      chk("top intact", got_m, 64'h1122_3344_5566_7788);

      for (int n = 0; n < 400; n++) begin
         ic  = 4'($urandom_range(0, 12));
         sel = $urandom_range(0, 9);
         if (sel < 8)       e = 64'($urandom_range(96, 160));
         else if (sel == 8) e = 64'($urandom_range(1000, 1030));
         else               e = {$urandom, $urandom};
         sel = $urandom_range(0, 9);
         if (sel < 8)       a = 64'($urandom_range(96, 160));
         else if (sel == 8) a = 64'($urandom_range(1000, 1030));
         else               a = {$urandom, $urandom};
         if (ic == 4'h4 || ic == 4'hA) a = (sel < 5) ? {$urandom, $urandom} : a;
         step(($urandom_range(0, 49) == 0), ic, e, a, {$urandom, $urandom},
              ($urandom_range(0, 15) != 0), ($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
